serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 13 +
 rtl/fs_cell.sv | 14 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: computes a - b - bi.
// Ports: a, b, bi (inputs); di difference bit, bo borrow-out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic di,
    output logic bo
);

    assign di = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = x - y - bin, one bit per clock, LSB first.
// Ports: clk, rst (async, active high), start, x, y, bin in;
//        busy, done (1-cycle pulse), d, bout, ovf out.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic cell_di;
    logic cell_bo;
    logic last_bit;

    fs_cell u_cell (
        .a  (xs_q[0]),
        .b  (ys_q[0]),
        .bi (borrow_q),
        .di (cell_di),
        .bo (cell_bo)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    xs_d     = x;
                    ys_d     = y;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                xs_d     = xs_q >> 1;
                ys_d     = ys_q >> 1;
                d_d      = {cell_di, d_q[WIDTH-1:1]};
                borrow_d = cell_bo;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    // xs_q[0]/ys_q[0] now hold the operand sign bits
                    bout_d  = cell_bo;
                    ovf_d   = (xs_q[0] != ys_q[0]) && (cell_di != xs_q[0]);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Results are compared against a plain-arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s8, b8, busy8, done8, bout8, ovf8;
    logic [7:0] x8, y8, d8;
    logic       s4, b4, busy4, done4, bout4, ovf4;
    logic [3:0] x4, y4, d4;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .x(x8), .y(y8), .bin(b8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .x(x4), .y(y4), .bin(b4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer difference, then reduce to w bits.
    function automatic void model(input int w, input longint xv,
                                  input longint yv, input longint bv,
                                  output logic [31:0] ed,
                                  output logic eb, output logic eo);
        longint full, sx, sy, sd, half;
        half = longint'(1) << (w - 1);
        full = xv - yv - bv;
        ed   = 32'(full & ((longint'(1) << w) - 1));
        eb   = (full < 0);
        sx   = (xv >= half) ? xv - 2 * half : xv;
        sy   = (yv >= half) ? yv - 2 * half : yv;
        sd   = sx - sy - bv;
        eo   = (sd < -half) || (sd > half - 1);
    endfunction

    task automatic wait_done8(output int lat);
        lat = 0;
        while (done8 !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] xv,
                          input logic [7:0] yv, input logic bv);
        logic [31:0] ed;
        logic        eb, eo;
        model(8, longint'(xv), longint'(yv), longint'(bv), ed, eb, eo);
        check({tag, "_d"}, 32'(d8), ed);
        check({tag, "_bout"}, 32'(bout8), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    endtask

    task automatic op8(input string tag, input logic [7:0] xv,
                       input logic [7:0] yv, input logic bv);
        int lat;
        @(negedge clk);
        x8 = xv; y8 = yv; b8 = bv; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(lat);
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_busy_done"}, 32'(busy8), 32'd0);
        check8(tag, xv, yv, bv);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int          lat;
        bit          saw;
        logic [7:0]  rx, ry;
        logic        rb;
        logic [31:0] ed;
        logic        eb, eo;

        rst = 1'b1;
        s8 = 0; x8 = 0; y8 = 0; b8 = 0;
        s4 = 0; x4 = 0; y4 = 0; b4 = 0;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_d", 32'(d8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op8("v1", 8'h05, 8'h03, 1'b0);
        check("v1_exp_d", 32'(d8), 32'h02);
        op8("v2", 8'h00, 8'h01, 1'b0);
        check("v2_exp_d", 32'(d8), 32'hFF);
        op8("v3", 8'h80, 8'h01, 1'b0);
        check("v3_exp_ovf", 32'(ovf8), 32'd1);
        op8("v4", 8'h7F, 8'hFF, 1'b0);
        check("v4_exp_d", 32'(d8), 32'h80);

        // Result holds while idle
        repeat (4) @(negedge clk);
        check("hold_d", 32'(d8), 32'h80);
        check("hold_bout", 32'(bout8), 32'd1);

        // Back-to-back with start held high through DONE
        @(negedge clk);
        x8 = 8'h10; y8 = 8'h0F; b8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        wait_done8(lat);
        check("b2b_lat1", 32'(lat), 32'd8);
        check8("b2b1", 8'h10, 8'h0F, 1'b1);
        check("b2b1_exp_d", 32'(d8), 32'h00);
        x8 = 8'h03; y8 = 8'h01; b8 = 1'b0;
        lat = 0;
        @(negedge clk);
        lat++;
        s8 = 1'b0;
        wait_done8(rx);
        lat += int'(rx);
        check("b2b_lat2", 32'(lat), 32'd9);
        check8("b2b2", 8'h03, 8'h01, 1'b0);
        check("b2b2_exp_d", 32'(d8), 32'h02);
        @(negedge clk);

        // Start in RUN cycle 3 must be ignored
        @(negedge clk);
        x8 = 8'h5A; y8 = 8'h33; b8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        x8 = 8'hFF; y8 = 8'h01; b8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        lat++;
        s8 = 1'b0;
        check("poke_busy", 32'(busy8), 32'd1);
        while (done8 !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        check("poke_lat", 32'(lat), 32'd8);
        check8("poke", 8'h5A, 8'h33, 1'b0);
        @(negedge clk);

        // Reset in RUN cycle 4 aborts with no done
        @(negedge clk);
        x8 = 8'hC3; y8 = 8'h21; b8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy8), 32'd0);
        check("mrst_d", 32'(d8), 32'd0);
        check("mrst_bout", 32'(bout8), 32'd0);
        check("mrst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) saw = 1'b1;
        end
        check("mrst_nodone", 32'(saw), 32'd0);
        op8("post_rst", 8'h12, 8'h34, 1'b1);

        // Random operands
        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 1'($urandom);
            op8("rnd", rx, ry, rb);
        end

        // Exhaustive at WIDTH=4
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    @(negedge clk);
                    x4 = 4'(xi); y4 = 4'(yi); b4 = 1'(bi); s4 = 1'b1;
                    @(negedge clk);
                    s4 = 1'b0;
                    lat = 0;
                    while (done4 !== 1'b1 && lat < 32) begin
                        @(negedge clk);
                        lat++;
                    end
                    model(4, longint'(xi), longint'(yi), longint'(bi),
                          ed, eb, eo);
                    check("w4_lat", 32'(lat), 32'd4);
                    check("w4_d", 32'(d4), ed);
                    check("w4_bout", 32'(bout4), 32'(eb));
                    check("w4_ovf", 32'(ovf4), 32'(eo));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
